hqm_rcfwl_gclk_sync_clkdist: RTL and testbench

Parametrised successor to the single-channel PCU clock-distribution stub. It retimes the PLL sync strobe and fans it out to NUM_CH grid partitions, each with its own enable and programmable skew delay. It also checks the strobe's periodicity with a lock state machine and flags missing or misplaced strobes. It sits between the global clock spine and the per-partition clock grids.

---
 rtl/hqm_rcfwl_gclk_sync_clkdist.sv | 143 ++++++++++++++
 tb/tb_hqm_rcfwl_gclk_sync_clkdist.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/hqm_rcfwl_gclk_sync_clkdist.sv
// Retimes the PLL sync strobe, fans it out to NUM_CH grid partitions with per-channel
// enable and skew delay, and monitors strobe periodicity with a lock FSM.
module hqm_rcfwl_gclk_sync_clkdist #(
    parameter int NUM_CH   = 4,
    parameter int DLY_W    = 3,
    parameter int PERIOD_W = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                      clkspine_in,
    input  logic                      rst,
    input  logic                      pll_sync_in,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH*DLY_W-1:0]   ch_dly,
    input  logic [PERIOD_W-1:0]       exp_period,
    output logic [NUM_CH-1:0]         pll_sync_out,
    output logic                      sync_lock,
    output logic                      sync_err,
    output logic [ERRCNT_W-1:0]       sync_err_cnt
);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    logic                s1_q, s2_q, s3_q;
    logic                sync_edge;
    logic [PERIOD_W-1:0] iv_q;
    logic [PERIOD_W:0]   exp_p1;
    state_t              state_q;
    logic                lock_q, err_q;
    logic [ERRCNT_W-1:0] errcnt_q;

    // s1/s2 resolve metastability; s3 is history so a long-held strobe yields one edge
    always_ff @(posedge clkspine_in) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pll_sync_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_edge = s2_q & ~s3_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DLY_W-1:0] cnt_q;
        logic             busy_q;
        logic             out_q;

        always_ff @(posedge clkspine_in) begin
            if (rst) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                out_q  <= 1'b0;
            end else begin
                out_q <= 1'b0;
                if (!ch_en[i]) begin
                    busy_q <= 1'b0;
                end else if (sync_edge) begin
                    cnt_q  <= ch_dly[i*DLY_W +: DLY_W];
                    busy_q <= 1'b1;
                end else if (busy_q) begin
                    if (cnt_q == '0) begin
                        out_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - DLY_W'(1);
                    end
                end
            end
        end

        assign pll_sync_out[i] = out_q;
    end

    always_ff @(posedge clkspine_in) begin
        if (rst)
            iv_q <= '0;
        else if (sync_edge)
            iv_q <= PERIOD_W'(1);
        else if (iv_q != '1)
            iv_q <= iv_q + PERIOD_W'(1);
    end

    assign exp_p1 = {1'b0, exp_period} + (PERIOD_W+1)'(1);

    // lock_q tracks the registered state so it is high exactly while state_q is LOCKED
    always_ff @(posedge clkspine_in) begin
        if (rst) begin
            state_q <= UNLOCKED;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            lock_q <= 1'b0;
            if (exp_period == '0) begin
                state_q <= UNLOCKED;
            end else begin
                case (state_q)
                    UNLOCKED: begin
                        if (sync_edge) state_q <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (sync_edge) begin
                            if (iv_q == exp_period) begin
                                state_q <= LOCKED;
                                lock_q  <= 1'b1;
                            end
                        end else if (iv_q > exp_period) begin
                            state_q <= UNLOCKED;
                        end
                    end
                    LOCKED: begin
                        lock_q <= 1'b1;
                        if (sync_edge && (iv_q != exp_period)) begin
                            err_q   <= 1'b1;
                            lock_q  <= 1'b0;
                            state_q <= ACQUIRE;
                        end else if (!sync_edge && ({1'b0, iv_q} == exp_p1)) begin
                            err_q   <= 1'b1;
                            lock_q  <= 1'b0;
                            state_q <= UNLOCKED;
                        end
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clkspine_in) begin
        if (rst)
            errcnt_q <= '0;
        else if (err_q && (errcnt_q != '1))
            errcnt_q <= errcnt_q + ERRCNT_W'(1);
    end

    assign sync_lock    = lock_q;
    assign sync_err     = err_q;
    assign sync_err_cnt = errcnt_q;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_sync_clkdist.sv
// Directed-vector bench for the sync strobe distributor and lock monitor.
module tb_hqm_rcfwl_gclk_sync_clkdist;
  localparam int NUM_CH = 4, DLY_W = 3, PERIOD_W = 8, ERRCNT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pll;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DLY_W-1:0] ch_dly;
  logic [PERIOD_W-1:0]     exp_period;
  logic [NUM_CH-1:0]       out;
  logic                    lock, err;
  logic [ERRCNT_W-1:0]     err_cnt;

  int n_chk = 0, n_pass = 0, err_seen = 0;

  always #5 clk = ~clk;

  hqm_rcfwl_gclk_sync_clkdist #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .PERIOD_W(PERIOD_W), .ERRCNT_W(ERRCNT_W)) dut (
    .clkspine_in(clk), .rst(rst), .pll_sync_in(pll), .ch_en(ch_en), .ch_dly(ch_dly),
    .exp_period(exp_period), .pll_sync_out(out), .sync_lock(lock), .sync_err(err),
    .sync_err_cnt(err_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (err) err_seen++;
  endtask

  // strobe high for one cycle, then low; next call starts n cycles later
  task automatic period(input int n);
    pll = 1'b1; tick();
    pll = 1'b0;
    repeat (n-1) tick();
  endtask

  initial begin
    int e0, c0, c1, c2, p0;
    logic [NUM_CH-1:0] ev;
    logic sticky;

    rst = 1'b1; pll = 1'b0; ch_en = '0; ch_dly = '0; exp_period = '0;
    repeat (3) tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    repeat (3) tick();

    // fan-out skew, strobe held high 10 cycles gives one edge only
    ch_en = 4'b1111;
    ch_dly = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 16; k++) begin
      pll = (k < 10);
      tick();
      for (int i = 0; i < NUM_CH; i++) ev[i] = (k == 3 + i);
      chk($sformatf("skew_k%0d", k), 32'(out), 32'(ev));
    end
    pll = 1'b0; ch_en = '0;
    repeat (4) tick();

    // acquire and lock at period 20
    exp_period = 8'd20;
    e0 = err_seen;
    period(20);
    chk("lock_after_e1", 32'(lock), 0);
    period(20);
    chk("lock_after_e2", 32'(lock), 1);
    repeat (48) period(20);
    chk("lock_50p", 32'(lock), 1);
    chk("noerr_50p", 32'(err_seen - e0), 0);
    chk("cnt_50p", 32'(err_cnt), 0);

    // short interval while locked
    period(19);
    period(20);
    chk("short_err", 32'(err_seen - e0), 1);
    chk("short_cnt", 32'(err_cnt), 1);
    chk("short_lock", 32'(lock), 0);
    period(20);
    chk("relock", 32'(lock), 1);

    // missing strobe: counter hits 21 four cycles after this point
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j >= 3 && j <= 5) chk($sformatf("miss_err_j%0d", j), 32'(err), 32'(j == 4));
    end
    chk("miss_cnt", 32'(err_cnt), 2);
    chk("miss_lock", 32'(lock), 0);

    // reload drops old pulse; disable cancels
    exp_period = '0;
    ch_en = 4'b1111;
    ch_dly = {3'd0, 3'd0, 3'd7, 3'd7};
    c0 = 0; c1 = 0; c2 = 0; p0 = -1;
    for (int k = 0; k < 20; k++) begin
      pll = (k == 0 || k == 4);
      if (k == 8) ch_en = 4'b1101;
      tick();
      if (out[0]) begin c0++; p0 = k; end
      if (out[1]) c1++;
      if (out[2]) c2++;
    end
    chk("reload_cnt0", 32'(c0), 1);
    chk("reload_pos0", 32'(p0), 14);
    chk("cancel_cnt1", 32'(c1), 0);
    chk("dly0_cnt2", 32'(c2), 2);
    pll = 1'b0; ch_en = '0;

    // error counter saturation: alternating intervals 3,4 at exp 3
    exp_period = 8'd3;
    e0 = err_seen;
    repeat (310) begin
      period(3);
      period(4);
    end
    chk("sat_errs", 32'(err_seen - e0), 309);
    chk("sat_cnt", 32'(err_cnt), 255);

    // checking disabled
    exp_period = '0;
    sticky = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pll = 1'b1; tick(); sticky |= lock | err;
      pll = 1'b0;
      repeat (1 + (i * 7) % 23) begin tick(); sticky |= lock | err; end
    end
    chk("dis_lockerr", 32'(sticky), 0);
    chk("dis_cnt", 32'(err_cnt), 255);

    // reset with pulses in flight and locked
    exp_period = 8'd20;
    period(20);
    period(20);
    chk("pre_rst_lock", 32'(lock), 1);
    ch_en = 4'b1111;
    ch_dly = {4{3'd7}};
    pll = 1'b1;
    repeat (4) tick();
    chk("pre_rst_pending", 32'(out), 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_lock", 32'(lock), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    tick();
    ch_dly = {3'd3, 3'd2, 3'd1, 3'd0};
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      tick();
      for (int i = 0; i < NUM_CH; i++) ev[i] = (k == 3 + i);
      chk($sformatf("post_rst_k%0d", k), 32'(out), 32'(ev));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
